// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bundle for instr_encoder.
// The source drives the request side; the encoder drives the write side.
interface instr_encoder_if #(
  parameter int MEM_DEPTH = 64,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               in_op;
  logic [1:0]               in_funct;
  logic [4:0]               in_rd;
  logic [4:0]               in_rs1;
  logic [4:0]               in_rs2;
  logic signed [63:0]       in_offset;
  logic                     in_last;
  logic                     mem_we;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [31:0]              mem_wdata;

  modport master (
    output in_valid, in_op, in_funct,
    output in_rd, in_rs1, in_rs2,
    output in_offset, in_last,
    input  in_ready,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_funct,
    input  in_rd, in_rs1, in_rs2,
    input  in_offset, in_last,
    output in_ready,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Program loader: encodes LD/SD/R/BEQ fields into RV64 words
// and writes them sequentially into instruction memory.
module instr_encoder #(
  parameter int MEM_DEPTH = 64,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  instr_encoder_if.slave      bus,
  output logic [ADDR_WIDTH:0] count,
  output logic                done,
  output logic                full,
  output logic                range_err
);

  localparam logic [1:0] OP_LD = 2'd0;
  localparam logic [1:0] OP_SD = 2'd1;
  localparam logic [1:0] OP_R  = 2'd2;
  localparam logic [1:0] OP_BQ = 2'd3;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_ALU   = 7'b0110011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_RUN,
    S_DONE,
    S_FULL,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  done_q, done_d;
  logic                  full_q, full_d;
  logic                  err_q, err_d;

  logic [31:0] enc;
  logic        uses_imm;
  logic        in_range;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [11:0] off;
  logic        xfer;

  assign off = bus.in_offset[11:0];

  assign in_range = (bus.in_offset >= -64'sd2048) &&
                    (bus.in_offset <= 64'sd2047);

  assign bus.in_ready = (state_q == S_RUN) && !rst;
  assign xfer = bus.in_valid && bus.in_ready;

  // Field encoder: build the instruction word from the request.
  always_comb begin
    enc      = '0;
    uses_imm = 1'b1;
    f7       = 7'b0000000;
    f3       = 3'b000;
    unique case (bus.in_funct)
      2'd0: begin f7 = 7'b0000000; f3 = 3'b000; end
      2'd1: begin f7 = 7'b0100000; f3 = 3'b000; end
      2'd2: begin f7 = 7'b0000000; f3 = 3'b111; end
      2'd3: begin f7 = 7'b0000000; f3 = 3'b110; end
    endcase
    unique case (bus.in_op)
      OP_LD: enc = {off, bus.in_rs1, 3'b011,
                    bus.in_rd, OPC_LOAD};
      OP_SD: enc = {off[11:5], bus.in_rs2, bus.in_rs1,
                    3'b011, off[4:0], OPC_STORE};
      OP_R: begin
        uses_imm = 1'b0;
        enc = {f7, bus.in_rs2, bus.in_rs1, f3,
               bus.in_rd, OPC_ALU};
      end
      OP_BQ: enc = {off[11], off[9:4], bus.in_rs2,
                    bus.in_rs1, 3'b000, off[3:0],
                    off[10], OPC_BR};
    endcase
  end

  // Next-state and write-port logic; only RUN accepts requests.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    done_d  = done_q;
    full_d  = full_q;
    err_d   = err_q;
    unique case (state_q)
      S_RUN: begin
        if (xfer) begin
          if (uses_imm && !in_range) begin
            err_d   = 1'b1;
            state_d = S_ERROR;
          end else begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_WIDTH-1:0];
            wdata_d = enc;
            count_d = count_q + 1'b1;
            if (count_d == DEPTH_C) begin
              full_d = 1'b1;
            end
            if (bus.in_last) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else if (count_d == DEPTH_C) begin
              state_d = S_FULL;
            end
          end
        end
      end
      S_DONE, S_FULL, S_ERROR: state_d = state_q;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      done_q  <= done_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign count         = count_q;
  assign done          = done_q;
  assign full          = full_q;
  assign range_err     = err_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-loader block that encodes instruction fields into 32-bit RV64 instruction words and writes them sequentially into instruction memory. It is the inverse of `imm_generator`: it scatters a signed offset into the I, S and SB immediate fields that `imm_generator` later gathers. It sits between the bench/boot stimulus source and the instruction memory write port. Fields are accepted over a valid/ready handshake, with one word written per accepted request.

## Interface
- `MEM_DEPTH`, 64: number of instruction words the block may write (addresses 0..MEM_DEPTH-1).
- `ADDR_WIDTH`, $clog2(MEM_DEPTH): width of `mem_addr` and `count`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request fields valid.
- `in_ready` out 1: block can accept this cycle.
- `in_op` in 2: 0=LD, 1=SD, 2=R-type, 3=BEQ.
- `in_funct` in 2: R-type only. 0=ADD, 1=SUB, 2=AND, 3=OR.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register indices.
- `in_offset` in 64 (longint signed): immediate. Units are bytes for LD/SD and halfwords for BEQ.
- `in_last` in 1: final instruction of the program.
- `mem_we` out 1: write strobe.
- `mem_addr` out ADDR_WIDTH: word address.
- `mem_wdata` out INSTRUCTION_WIDTH (32): encoded word.
- `count` out ADDR_WIDTH+1: words written so far.
- `done` out 1: program complete (sticky).
- `full` out 1: MEM_DEPTH words written (sticky).
- `range_err` out 1: offset out of range (sticky).

## Operation
- FSM states: RUN, DONE, FULL, ERROR. Reset enters RUN.
- `in_ready` = (state==RUN). A transfer occurs when `in_valid && in_ready`.
- Encoding uses common_pkg opcodes. Unused fields are forced to 0.
  - LD: {off[11:0], rs1, 3'b011, rd, 7'b0000011}. `rs2` is ignored.
  - SD: {off[11:5], rs2, rs1, 3'b011, off[4:0], 7'b0100011}. `rd` is ignored.
  - R: {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
    - ADD: 0000000/000. SUB: 0100000/000. AND: 0000000/111. OR: 0000000/110.
  - BEQ: {off[11], off[9:4], rs2, rs1, 3'b000, off[3:0], off[10], 7'b1100011}. Here `off` is the halfword count, so `off[11:0]` maps to imm[12:1]. `rd` is ignored.
- Range check for LD/SD/BEQ: -2048 <= in_offset <= 2047, over the full 64-bit value.
  - Out of range: no write, `range_err`<=1, state goes to ERROR.
  - R-type ignores `in_offset` and never flags an error.
- On a valid transfer:
  - The word is written at address `count`, and `count` increments.
  - If `in_last`: state goes to DONE and `done`<=1.
  - Else if the new count == MEM_DEPTH: state goes to FULL and `full`<=1.
  - `in_last` on the MEM_DEPTH-th word sets both `done` and `full`, and state goes to DONE.
- DONE, FULL and ERROR are terminal. `in_ready` stays 0 and nothing is written until `rst`.
- An `in_last` that arrives with an out-of-range offset sets only `range_err`.
- Addresses never wrap. The write at address MEM_DEPTH-1 is always the last write.

## Timing
- Reset values: `in_ready`=1 in the cycle after reset deasserts. All other outputs are 0: `mem_we`, `mem_addr`, `mem_wdata`, `count`, `done`, `full`, `range_err`.
  - While `rst`=1, `in_ready`=0.
- Latency is one cycle. A transfer at edge N drives `mem_we`=1, `mem_addr` and `mem_wdata` during cycle N+1. `count` updates at edge N.
- `mem_we` is a single-cycle pulse per transfer. Throughput is one word per cycle, and back-to-back transfers give consecutive addresses.
- `mem_addr`/`mem_wdata` hold their last values when `mem_we`=0.
- `done`/`full`/`range_err` assert in the same cycle as the final `mem_we`, or one cycle after the rejected transfer. `in_ready` drops in that same cycle.
- `rst` mid-program cancels any pending write: `mem_we`=0 in the cycle after the reset edge. `count` returns to 0.

## Test plan
- LD rd=8, rs1=4, off=15 -> `mem_we` at addr 0, wdata 32'b00000000111100100011010000000011, `count`=1.
- SD rs1=4, rs2=8, off=-2001, then R ADD rd=16, rs1=4, rs2=8, both back-to-back:
  - addr 0: 32'b10000010100000100011011110100011.
  - addr 1: 32'b00000000100000100000100000110011.
  - `mem_we` is high for exactly two consecutive cycles.
- BEQ rs1=4, rs2=8, off=-1745 with `in_last`=1 -> wdata 32'b10100100100000100000111101100011. `done`=1, `in_ready`=0, and further `in_valid` produces no writes.
- LD off=2048, then off=-2049 (separate runs) -> no `mem_we`, `range_err`=1, `count` unchanged, `in_ready`=0. Off=2047 and off=-2048 are accepted.
- Stream MEM_DEPTH R-type words with `in_valid` held high:
  - Last write goes to addr MEM_DEPTH-1 and `full`=1.
  - `in_ready`=0 afterward, and no write occurs at addr 0 again.
- Assert `rst` the cycle after a transfer:
  - `mem_we`=0 after the reset edge, all outputs return to reset values, and `count`=0.
  - The next transfer writes addr 0.
